riv_async_fifo_ptr_rx: RTL and testbench
========================================

# riv_async_fifo_ptr_rx

Receive end of the async-FIFO pointer-crossing handshake. It synchronises the far domain's level request and captures the far domain's quasi-static pointer bus. It then returns a four-phase acknowledge and presents the captured pointer, with a one-cycle valid, to the local full/empty logic. One instance sits in each clock domain of the FIFO, opposite the far side's pointer-transmit controller.

## Interface
- `ADDR_WIDTH`, 10: pointer width in bits, including the wrap bit.
- `SYNC_STAGES`, 2: synchroniser depth on `fsm_req`; legal values are 2 to 4.
- `TIMEOUT_CYCLES`, 1024: watchdog limit, in local cycles; used only with `RIV_ASYNC_FIFO_PTR_RX_TIMEOUT_EN`.
- `clk` in 1: local clock.
- `rst` in 1: reset, synchronous and active-high.
- `fsm_req` in 1: far-domain request level, asynchronous to `clk`.
- `fsm_data` in ADDR_WIDTH: far-domain pointer. It is stable whenever `fsm_req` is high and is never synchronised.
- `fsm_ack` out 1: acknowledge to the far domain, driven directly from a flop.
- `addr` out ADDR_WIDTH: last captured far pointer.
- `addr_vld` out 1: one-cycle pulse, high in the first cycle a new `addr` is visible.
- `err` out 1: sticky watchdog error.

## Operation
- Synchroniser:
  - `fsm_req` passes through `SYNC_STAGES` flops to produce `req_s`.
  - All synchroniser flops clear on `rst`.
- FSM states (encoding and transitions):
  - RESET=0: go to IDLE.
  - IDLE=1: go to CAPTURE if `req_s`, otherwise stay.
  - CAPTURE=2: `addr <= fsm_data`, then go to ACK.
  - ACK=3: go to IDLE if `!req_s`, otherwise stay.
  - Encodings 4–7 go to RESET.
- Outputs:
  - `fsm_ack = (fsm == ACK)`.
  - `addr_vld` is a registered pulse, set on the edge leaving CAPTURE and cleared on the next edge.
- Duplicate capture of the same pointer is harmless, because pointer values are idempotent.
- `addr` changes only on the CAPTURE edge. At every other time it holds its value.
- Wrap-around: `addr` is copied bit-for-bit. The block does no arithmetic on it; wrap interpretation belongs to the consumer.
- Arbitrary `fsm_req` pulses shorter than one local cycle are out of protocol. The far side holds `fsm_req` until it sees `fsm_ack`.

## Timing
- Reset values: `fsm`=RESET, `fsm_ack`=0, `addr`=0, `addr_vld`=0, `err`=0, synchroniser flops 0.
- Let edge 0 be the first `clk` edge that samples `fsm_req`=1.
  - `req_s`=1 after edge `SYNC_STAGES-1`.
  - CAPTURE begins after edge `SYNC_STAGES`.
  - `addr`, `addr_vld` and `fsm_ack` all go high after edge `SYNC_STAGES+1`.
- Release: `fsm_ack` falls on the edge after the one on which `req_s` samples 0. Falling-edge latency is therefore `SYNC_STAGES+1` edges.
- Minimum handshake, in local cycles: `2*SYNC_STAGES+3`, plus the far-domain synchronisation time.
- Reset mid-handshake:
  - `fsm_ack` drops on the reset edge.
  - If `fsm_req` is still high after reset, the block recaptures `fsm_data` and re-acknowledges.
- `req_s` falling in CAPTURE cannot occur in protocol. If it does, the block still enters ACK, then leaves for IDLE one cycle later.

## Configuration
- Macro: `RIV_ASYNC_FIFO_PTR_RX_TIMEOUT_EN`.
- Defined:
  - A counter, `$clog2(TIMEOUT_CYCLES+1)` bits wide, increments each cycle in ACK and saturates at `TIMEOUT_CYCLES`.
  - The counter clears outside ACK.
  - Reaching `TIMEOUT_CYCLES` sets `err`. `err` stays set until `rst`.
  - FSM behaviour is unchanged.
- Undefined: no counter is built and `err` is tied to 0.

## Structure
- `riv_async_fifo_pkg` holds the `fsm_rx_t` enum, shared alongside the transmit-side FSM type.
- Sub-module `riv_sync_bit #(STAGES)` implements the multi-flop synchroniser with a synchronous active-high clear.
  - Each synchroniser flop carries the codebase's async-register attribute.

## Test plan
- **Basic handshake.** `SYNC_STAGES`=2; `fsm_data`=0x155; `fsm_req` rises, then falls once `fsm_ack` is seen.
  - `fsm_ack` goes high 3 edges after the first sampling edge.
  - `addr`=0x155 and a single `addr_vld` pulse occur at the same time.
  - `fsm_ack` falls 3 edges after `fsm_req` falls.
- **Back-to-back transfers.** Send pointers 0x3FE, 0x3FF, 0x000 in sequence.
  - `addr` follows exactly.
  - Exactly one `addr_vld` per transfer; the wrap is passed through unchanged.
- **Data changes outside the request window.** Toggle `fsm_data` while `fsm_req` is low.
  - `addr` does not change and `addr_vld` stays 0.
- **Reset mid-handshake.** Assert `rst` for 1 cycle while in ACK, with `fsm_req` still high.
  - `fsm_ack`=0 and `addr`=0 after the reset edge.
  - A re-acknowledge follows `SYNC_STAGES+2` edges later.
- **Watchdog, macro defined.** `TIMEOUT_CYCLES`=8; hold `fsm_req` high forever.
  - `err` rises 8 cycles after `fsm_ack` rises and stays high after `fsm_req` is released.
- **Watchdog, macro undefined.** Same stimulus: `err` stays 0 throughout.

Source files
------------

// File: rtl/riv_async_fifo_pkg.sv
// rtl/riv_async_fifo_pkg.sv - shared FSM state types for the async-FIFO pointer handshake
package riv_async_fifo_pkg;

    typedef enum logic [2:0] {
        RX_RESET   = 3'd0,
        RX_IDLE    = 3'd1,
        RX_CAPTURE = 3'd2,
        RX_ACK     = 3'd3
    } fsm_rx_t;

    typedef enum logic [2:0] {
        TX_RESET = 3'd0,
        TX_IDLE  = 3'd1,
        TX_REQ   = 3'd2,
        TX_WAIT  = 3'd3
    } fsm_tx_t;

endpackage

// File: rtl/riv_sync_bit.sv
// rtl/riv_sync_bit.sv - multi-flop single-bit synchroniser with synchronous active-high clear
module riv_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/riv_async_fifo_ptr_rx.sv
// rtl/riv_async_fifo_ptr_rx.sv - receive side of the async-FIFO pointer four-phase handshake
// Optional watchdog: RIV_ASYNC_FIFO_PTR_RX_TIMEOUT_EN
module riv_async_fifo_ptr_rx
    import riv_async_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fsm_req,
    input  logic [ADDR_WIDTH-1:0] fsm_data,
    output logic                  fsm_ack,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  addr_vld,
    output logic                  err
);

    logic                  w_req_s;
    fsm_rx_t               r_state;
    fsm_rx_t               w_state_nxt;
    logic                  r_ack;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_addr_vld;

    riv_sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync_req (
        .clk (clk),
        .rst (rst),
        .i_d (fsm_req),
        .o_q (w_req_s)
    );

    always_comb begin
        w_state_nxt = RX_RESET;
        case (r_state)
            RX_RESET:   w_state_nxt = RX_IDLE;
            RX_IDLE:    w_state_nxt = w_req_s ? RX_CAPTURE : RX_IDLE;
            RX_CAPTURE: w_state_nxt = RX_ACK;
            RX_ACK:     w_state_nxt = w_req_s ? RX_ACK : RX_IDLE;
            default:    w_state_nxt = RX_RESET;
        endcase
    end

    // Ack gets its own flop, loaded from the next state, so it reaches the far domain glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RX_RESET;
            r_ack      <= 1'b0;
            r_addr     <= '0;
            r_addr_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ack      <= (w_state_nxt == RX_ACK);
            r_addr_vld <= (r_state == RX_CAPTURE);
            if (r_state == RX_CAPTURE) begin
                r_addr <= fsm_data;
            end
        end
    end

    assign fsm_ack  = r_ack;
    assign addr     = r_addr;
    assign addr_vld = r_addr_vld;

`ifdef RIV_ASYNC_FIFO_PTR_RX_TIMEOUT_EN
    localparam int              LP_CW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LP_CW-1:0] LP_MAX = LP_CW'(TIMEOUT_CYCLES);

    logic [LP_CW-1:0] r_cnt;
    logic [LP_CW-1:0] w_cnt_nxt;
    logic             r_err;

    always_comb begin
        w_cnt_nxt = '0;
        if (r_state == RX_ACK) begin
            w_cnt_nxt = (r_cnt == LP_MAX) ? r_cnt : r_cnt + 1'b1;
        end
    end

    // err is set on the same edge the count reaches the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_err <= r_err | (w_cnt_nxt == LP_MAX);
        end
    end

    assign err = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_riv_async_fifo_ptr_rx.sv
// tb/tb_riv_async_fifo_ptr_rx.sv - randomized self-checking bench for riv_async_fifo_ptr_rx
module tb_riv_async_fifo_ptr_rx;

    localparam int AW = 10;
    localparam int S  = 2;
    localparam int T  = 8;
`ifdef RIV_ASYNC_FIFO_PTR_RX_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          fsm_req;
    logic [AW-1:0] fsm_data;
    logic          fsm_ack;
    logic [AW-1:0] addr;
    logic          addr_vld;
    logic          err;

    int            total = 0;
    int            bad   = 0;
    logic [AW-1:0] exp_addr;
    logic          exp_err;

    riv_async_fifo_ptr_rx #(
        .ADDR_WIDTH    (AW),
        .SYNC_STAGES   (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .fsm_req (fsm_req),
        .fsm_data(fsm_data),
        .fsm_ack (fsm_ack),
        .addr    (addr),
        .addr_vld(addr_vld),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare every output against the expected values for this cycle.
    task automatic check_cycle(input string tag, input logic ack_e, input logic vld_e);
        total++;
        if (fsm_ack !== ack_e) begin
            bad++;
            $display("FAIL %s ack: got %b want %b", tag, fsm_ack, ack_e);
        end
        total++;
        if (addr_vld !== vld_e) begin
            bad++;
            $display("FAIL %s vld: got %b want %b", tag, addr_vld, vld_e);
        end
        total++;
        if (addr !== exp_addr) begin
            bad++;
            $display("FAIL %s addr: got %h want %h", tag, addr, exp_addr);
        end
        total++;
        if (err !== exp_err) begin
            bad++;
            $display("FAIL %s err: got %b want %b", tag, err, exp_err);
        end
    endtask

    // Request rises; ack, addr and a single vld appear together S+2 edges later.
    task automatic rise(input string tag, input logic [AW-1:0] d);
        fsm_data = d;
        fsm_req  = 1'b1;
        for (int n = 0; n <= S + 1; n++) begin
            step();
            if (n == S + 1) exp_addr = d;
            check_cycle(tag, n == S + 1, n == S + 1);
        end
    endtask

    // Request falls after a hold; ack falls on the edge numbered S counted from the first low sample.
    task automatic release_req(input string tag, input int hold, input int gap);
        for (int h = 0; h < hold; h++) begin
            step();
            check_cycle(tag, 1'b1, 1'b0);
        end
        fsm_req  = 1'b0;
        fsm_data = AW'($urandom);
        for (int n = 0; n <= S; n++) begin
            step();
            check_cycle(tag, n < S, 1'b0);
        end
        for (int g = 0; g < gap; g++) begin
            fsm_data = AW'($urandom);
            step();
            check_cycle(tag, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        fsm_req = 1'b0;
        step();
        step();
        rst      = 1'b0;
        exp_addr = '0;
        exp_err  = 1'b0;
    endtask

    task automatic test_reset();
        fsm_data = AW'($urandom);
        do_reset();
        check_cycle("reset", 1'b0, 1'b0);
        step();
        check_cycle("reset_idle", 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        rise("basic", AW'(10'h155));
        release_req("basic_rel", 2, 1);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] ptrs [3];
        ptrs[0] = AW'(10'h3FE);
        ptrs[1] = AW'(10'h3FF);
        ptrs[2] = AW'(10'h000);
        for (int i = 0; i < 3; i++) begin
            rise("b2b", ptrs[i]);
            release_req("b2b_rel", 0, 0);
        end
    endtask

    task automatic test_data_outside_window();
        for (int i = 0; i < 12; i++) begin
            fsm_data = AW'($urandom);
            step();
            check_cycle("quiet", 1'b0, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            rise("rand", AW'($urandom));
            release_req("rand_rel", $urandom_range(0, 5), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_handshake();
        logic [AW-1:0] d;
        d = AW'($urandom_range(1, 1023));
        rise("mid", d);
        step();
        check_cycle("mid_hold", 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst      = 1'b0;
        exp_addr = '0;
        exp_err  = 1'b0;
        check_cycle("mid_rst", 1'b0, 1'b0);
        for (int n = 1; n <= S + 2; n++) begin
            step();
            if (n == S + 2) exp_addr = d;
            check_cycle("mid_reack", n == S + 2, n == S + 2);
        end
        release_req("mid_rel", 1, 1);
    endtask

    task automatic test_watchdog();
        rise("wd", AW'($urandom));
        for (int k = 1; k <= T + 4; k++) begin
            step();
            if (WD_EN && k >= T) exp_err = 1'b1;
            check_cycle("wd_hold", 1'b1, 1'b0);
        end
        release_req("wd_rel", 0, 3);
        rise("wd_again", AW'($urandom));
        release_req("wd_again_rel", 1, 1);
        do_reset();
        check_cycle("wd_clear", 1'b0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        fsm_req  = 1'b0;
        fsm_data = '0;
        exp_addr = '0;
        exp_err  = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_data_outside_window();
        test_random();
        test_reset_mid_handshake();
        test_watchdog();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
